// File: rtl/tt_um_warriorjacq9_pkg.sv
// Shared types for the warriorjacq9 4-bit ALU core: opcodes, bus-request codes, FSM states.
package tt_um_warriorjacq9_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADDI = 4'b0001,
        OP_SUBI = 4'b0010,
        OP_ANDI = 4'b0011,
        OP_ORI  = 4'b0100,
        OP_XORI = 4'b0101,
        OP_ADDN = 4'b0110
    } opcode_t;

    typedef logic [3:0] busreq_t;
    localparam busreq_t BUSREQ_IDLE    = 4'b0000;
    localparam busreq_t BUSREQ_REGREAD = 4'b0001;
    localparam busreq_t BUSREQ_NEXTOP  = 4'b0011;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_REQ   = 2'd1,
        ST_NEXT  = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    // NOP and unassigned codes never leave FETCH.
    function automatic logic is_exec_op(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd6);
    endfunction

endpackage

// File: rtl/warriorjacq9_alu.sv
// Combinational 4-bit ALU; carry holds the carry-out for adds and the borrow for SUBI.
module warriorjacq9_alu
    import tt_um_warriorjacq9_pkg::*;
(
    input  opcode_t    op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y,
    output logic       carry,
    output logic       zero
);

    logic [4:0] sum;
    logic [4:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y     = a;
        carry = 1'b0;
        case (op)
            OP_ADDI, OP_ADDN: begin
                y     = sum[3:0];
                carry = sum[4];
            end
            OP_SUBI: begin
                y     = diff[3:0];
                carry = diff[4];
            end
            OP_ANDI: y = a & b;
            OP_ORI:  y = a | b;
            OP_XORI: y = a ^ b;
            default: y = a;
        endcase
    end

    assign zero = (y == 4'h0);

endmodule

// File: rtl/tt_um_warriorjacq9.sv
// TinyTapeout wrapper and sequencing FSM for the 4-bit ALU core.
// Optional macro FLAGS_EN adds registered carry/zero flags and a busy bit on uo_out[6:4].
//
// state | meaning
// FETCH | latch opcode/immediate from ui_in, request register if legal
// REQ   | latch register value from uio_in
// NEXT  | latch next operand nibble from ui_in[7:4] (ADDN only)
// EXEC  | write ALU result back
module tt_um_warriorjacq9
    import tt_um_warriorjacq9_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    state_t     state;
    opcode_t    op_q;
    logic [3:0] imm_q;
    logic [3:0] reg_q;
    logic [3:0] result_q;
    busreq_t    busreq_q;

    logic [3:0] alu_y;
    logic       alu_carry;
    logic       alu_zero;

    warriorjacq9_alu u_alu (
        .op    (op_q),
        .a     (reg_q),
        .b     (imm_q),
        .y     (alu_y),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            op_q     <= OP_NOP;
            imm_q    <= 4'h0;
            reg_q    <= 4'h0;
            result_q <= 4'h0;
            busreq_q <= BUSREQ_IDLE;
        end else begin
            case (state)
                ST_FETCH: begin
                    op_q  <= opcode_t'(ui_in[3:0]);
                    imm_q <= ui_in[7:4];
                    if (is_exec_op(ui_in[3:0])) begin
                        state    <= ST_REQ;
                        busreq_q <= BUSREQ_REGREAD;
                    end else begin
                        busreq_q <= BUSREQ_IDLE;
                    end
                end
                ST_REQ: begin
                    reg_q <= uio_in[3:0];
                    if (op_q == OP_ADDN) begin
                        state    <= ST_NEXT;
                        busreq_q <= BUSREQ_NEXTOP;
                    end else begin
                        state    <= ST_EXEC;
                        busreq_q <= BUSREQ_IDLE;
                    end
                end
                ST_NEXT: begin
                    imm_q    <= ui_in[7:4];
                    state    <= ST_EXEC;
                    busreq_q <= BUSREQ_IDLE;
                end
                ST_EXEC: begin
                    result_q <= alu_y;
                    state    <= ST_FETCH;
                    busreq_q <= BUSREQ_IDLE;
                end
                default: begin
                    state    <= ST_FETCH;
                    busreq_q <= BUSREQ_IDLE;
                end
            endcase
        end
    end

`ifdef FLAGS_EN
    logic carry_q;
    logic zero_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state == ST_EXEC) begin
            carry_q <= alu_carry;
            zero_q  <= alu_zero;
        end
    end

    assign uo_out = {1'b0, (state != ST_FETCH), zero_q, carry_q, busreq_q};

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[7:4]};
`else
    assign uo_out = {4'h0, busreq_q};

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[7:4], alu_carry, alu_zero};
`endif

    assign uio_out = {4'h0, result_q};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_warriorjacq9.sv
// Directed self-checking bench for tt_um_warriorjacq9; flag checks follow FLAGS_EN.
module tb_tt_um_warriorjacq9;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_fail;

    tt_um_warriorjacq9 dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Upper status nibble expected at a given point: {0, busy, zero, carry} or 0 without flags.
    function automatic logic [3:0] status(input logic busy, input logic z, input logic c);
`ifdef FLAGS_EN
        return {1'b0, busy, z, c};
`else
        return 4'h0 & {1'b0, busy, z, c};
`endif
    endfunction

    // One immediate instruction from FETCH through writeback; prev_z/prev_c are the flags still held.
    task automatic run_imm(input string tag, input logic [7:0] instr, input logic [3:0] regv,
                           input logic [3:0] exp_y, input logic exp_c, input logic exp_z,
                           input logic prev_z, input logic prev_c);
        ui_in  = instr;
        uio_in = {4'h0, regv};
        step();
        check({tag, "_regread"}, uo_out, {status(1'b1, prev_z, prev_c), 4'b0001});
        step();
        check({tag, "_exec_busreq"}, uo_out, {status(1'b1, prev_z, prev_c), 4'b0000});
        step();
        check({tag, "_result"}, uio_out, {4'h0, exp_y});
        check({tag, "_status"}, uo_out, {status(1'b0, exp_z, exp_c), 4'b0000});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ena      = 1'b1;
        rst_n    = 1'b0;
        ui_in    = 8'h00;
        uio_in   = 8'h00;
        @(negedge clk);
        step();
        step();
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h0F);

        rst_n = 1'b1;
        run_imm("addi2", 8'h21, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        run_imm("addi2_rerun", 8'h21, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);

        // ADDI 3 with the instruction changed after fetch; the latched opcode must win.
        ui_in  = 8'h31;
        uio_in = 8'h04;
        step();
        check("addi3_regread", uo_out[3:0], 4'b0001);
        ui_in = 8'h05;
        step();
        check("addi3_exec_busreq", uo_out[3:0], 4'b0000);
        step();
        check("addi3_result", uio_out, 8'h07);

        // ADDN: register 4, next operand 1.
        ui_in  = 8'h06;
        uio_in = 8'h04;
        step();
        check("addn_regread", uo_out[3:0], 4'b0001);
        step();
        check("addn_nextop", uo_out[3:0], 4'b0011);
        ui_in = 8'h16;
        step();
        check("addn_idle", uo_out[3:0], 4'b0000);
        check("addn_result_held", uio_out, 8'h07);
        step();
        check("addn_result", uio_out, 8'h05);
        check("addn_status", uo_out, {status(1'b0, 1'b0, 1'b0), 4'b0000});

        run_imm("wrap_add", 8'h11, 4'd15, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        run_imm("wrap_sub", 8'h12, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1);
        run_imm("ori", 8'h94, 4'd6, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
        run_imm("xori", 8'hF5, 4'd6, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        run_imm("andi_zero", 8'h33, 4'd4, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_imm("subi", 8'h32, 4'd9, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);

        // NOP and an illegal opcode: stay idle, result and flags hold.
        ui_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("nop_busreq", uo_out, {status(1'b0, 1'b0, 1'b0), 4'b0000});
            check("nop_hold", uio_out, 8'h06);
        end
        ui_in = 8'h5A;
        step();
        check("illegal_busreq", uo_out[3:0], 4'b0000);
        check("illegal_hold", uio_out, 8'h06);

        // Reset while in REQ aborts the instruction.
        ui_in  = 8'h21;
        uio_in = 8'h04;
        step();
        check("midreset_regread", uo_out[3:0], 4'b0001);
        rst_n = 1'b0;
        step();
        check("midreset_uo_out", uo_out, 8'h00);
        check("midreset_uio_out", uio_out, 8'h00);
        rst_n = 1'b1;
        run_imm("after_reset", 8'h21, 4'd4, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
